// File: rtl/reg_bridge.sv
// Host-link to mapper-mux register bridge: decodes command frames and paces 12-bit
// register writes so a slow toggle-synchronised consumer samples each one.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_CMD     | waiting for the command byte {op, addr}
// S_WR_LO   | waiting for low data byte of a write
// S_WR_HI   | waiting for high nibble byte; submits the write
// S_TX      | shifting out the status snapshot, one byte per tx_req
// S_DISCARD | frame finished or unknown; ignore everything until frame_start
module reg_bridge #(
  parameter int HOLD_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_req,
  output logic [7:0]  tx_data,
  output logic [11:0] wr_reg,
  output logic [3:0]  wr_reg_addr,
  output logic        wr_reg_changed,
  input  logic [31:0] status_reg,
  output logic        busy
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {S_CMD, S_WR_LO, S_WR_HI, S_TX, S_DISCARD} state_t;

  state_t        state, cur_state, state_nxt;
  logic [7:0]    tx_nxt, lo, lo_nxt;
  logic [31:0]   snap, snap_nxt;
  logic [1:0]    idx, idx_nxt;
  logic [3:0]    cmd_addr, addr_nxt;
  logic          submit, ovf_clr, overflow, ovf_nxt;
  logic [11:0]   sub_data;

  logic [CW-1:0] hold_cnt, cnt_nxt;
  logic          hold_zero, issue_pend, issue_new, drop, store;
  logic          pend_valid, pend_nxt;
  logic [11:0]   pend_data;
  logic [3:0]    pend_addr;

  // frame_start restarts the frame in the same cycle, so a coincident byte is a command
  always_comb begin
    cur_state = frame_start ? S_CMD : state;
    state_nxt = cur_state;
    tx_nxt    = frame_start ? 8'h00 : tx_data;
    snap_nxt  = snap;
    idx_nxt   = idx;
    lo_nxt    = lo;
    addr_nxt  = cmd_addr;
    submit    = 1'b0;
    ovf_clr   = 1'b0;
    case (cur_state)
      S_CMD: if (rx_valid) begin
        addr_nxt = rx_data[3:0];
        case (rx_data[7:4])
          4'h1: state_nxt = S_WR_LO;
          4'h2: begin
            snap_nxt  = status_reg;
            tx_nxt    = status_reg[7:0];
            idx_nxt   = 2'd0;
            state_nxt = S_TX;
          end
          4'h3: begin
            tx_nxt    = {6'b0, overflow, busy};
            ovf_clr   = 1'b1;
            state_nxt = S_DISCARD;
          end
          default: state_nxt = S_DISCARD;
        endcase
      end
      S_WR_LO: if (rx_valid) begin
        lo_nxt    = rx_data;
        state_nxt = S_WR_HI;
      end
      S_WR_HI: if (rx_valid) begin
        submit    = 1'b1;
        state_nxt = S_DISCARD;
      end
      S_TX: if (tx_req) begin
        if (idx == 2'd3) begin
          tx_nxt    = 8'h00;
          state_nxt = S_DISCARD;
        end else begin
          idx_nxt = idx + 2'd1;
          tx_nxt  = snap[{idx_nxt, 3'b000} +: 8];
        end
      end
      default: ;
    endcase
  end

  assign sub_data = {rx_data[3:0], lo};

  // A write arriving as the slot drains refills the slot instead of being dropped
  always_comb begin
    hold_zero  = (hold_cnt == '0);
    issue_pend = hold_zero & pend_valid;
    issue_new  = hold_zero & ~pend_valid & submit;
    drop       = submit & pend_valid & ~hold_zero;
    store      = submit & ~issue_new & ~drop;
    cnt_nxt    = hold_cnt;
    if (issue_pend || issue_new)
      cnt_nxt = HOLD_LOAD;
    else if (!hold_zero)
      cnt_nxt = hold_cnt - CW'(1);
    pend_nxt = pend_valid;
    if (store)
      pend_nxt = 1'b1;
    else if (issue_pend)
      pend_nxt = 1'b0;
    ovf_nxt = drop | (overflow & ~ovf_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_CMD;
      tx_data        <= 8'h00;
      snap           <= '0;
      idx            <= 2'd0;
      lo             <= 8'h00;
      cmd_addr       <= 4'h0;
      overflow       <= 1'b0;
      hold_cnt       <= '0;
      pend_valid     <= 1'b0;
      pend_data      <= '0;
      pend_addr      <= '0;
      wr_reg         <= '0;
      wr_reg_addr    <= '0;
      wr_reg_changed <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state      <= state_nxt;
      tx_data    <= tx_nxt;
      snap       <= snap_nxt;
      idx        <= idx_nxt;
      lo         <= lo_nxt;
      cmd_addr   <= addr_nxt;
      overflow   <= ovf_nxt;
      hold_cnt   <= cnt_nxt;
      pend_valid <= pend_nxt;
      busy       <= (cnt_nxt != '0) | pend_nxt;
      if (store) begin
        pend_data <= sub_data;
        pend_addr <= cmd_addr;
      end
      if (issue_pend) begin
        wr_reg         <= pend_data;
        wr_reg_addr    <= pend_addr;
        wr_reg_changed <= ~wr_reg_changed;
      end else if (issue_new) begin
        wr_reg         <= sub_data;
        wr_reg_addr    <= cmd_addr;
        wr_reg_changed <= ~wr_reg_changed;
      end
    end
  end

endmodule

// File: tb/tb_reg_bridge.sv
// Directed bench for reg_bridge: per-cycle vector table for frame decoding plus
// hand-timed sequences for hold-off pacing, pending slot, overflow and reset.
module tb_reg_bridge;

  logic        clk = 1'b0;
  logic        reset, frame_start, rx_valid, tx_req;
  logic [7:0]  rx_data;
  logic [31:0] status_reg;
  logic [7:0]  tx_data;
  logic [11:0] wr_reg;
  logic [3:0]  wr_reg_addr;
  logic        wr_reg_changed, busy;

  always #5 clk = ~clk;

  reg_bridge #(.HOLD_CYCLES(256)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .rx_valid(rx_valid),
    .rx_data(rx_data), .tx_req(tx_req), .tx_data(tx_data), .wr_reg(wr_reg),
    .wr_reg_addr(wr_reg_addr), .wr_reg_changed(wr_reg_changed),
    .status_reg(status_reg), .busy(busy)
  );

  typedef struct {
    logic        fs, rv;
    logic [7:0]  rd;
    logic        tr;
    logic [31:0] st;
    logic [7:0]  tx;
    logic [11:0] wr;
    logic [3:0]  ad;
    logic        ch, bz;
  } vec_t;

  vec_t vt[31];

  int n_checks = 0, n_fail = 0;
  int cyc = 0, ntog = 0, tog_cyc = 0, glitch = 0;
  logic        prev_chg;
  logic [15:0] prev_wr;

  function automatic vec_t mk(logic fs, logic rv, logic [7:0] rd, logic tr, logic [31:0] st,
                              logic [7:0] tx, logic [11:0] wr, logic [3:0] ad, logic ch, logic bz);
    vec_t v;
    v.fs = fs; v.rv = rv; v.rd = rd; v.tr = tr; v.st = st;
    v.tx = tx; v.wr = wr; v.ad = ad; v.ch = ch; v.bz = bz;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one clock; records wr_reg_changed toggles and any write-bus change without a toggle
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (wr_reg_changed !== prev_chg) begin
      ntog++;
      tog_cyc = cyc;
    end else if ({wr_reg_addr, wr_reg} !== prev_wr) begin
      glitch++;
    end
    prev_chg = wr_reg_changed;
    prev_wr  = {wr_reg_addr, wr_reg};
  endtask

  task automatic drive(input logic fs, input logic rv, input logic [7:0] rd, input logic tr);
    frame_start = fs; rx_valid = rv; rx_data = rd; tx_req = tr;
    tick();
    frame_start = 1'b0; rx_valid = 1'b0; tx_req = 1'b0;
  endtask

  task automatic wr_frame(input logic [7:0] cmd, input logic [7:0] lo, input logic [7:0] hi);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b1, cmd, 1'b0);
    drive(1'b0, 1'b1, lo, 1'b0);
    drive(1'b0, 1'b1, hi, 1'b0);
  endtask

  task automatic read_flags(input string name, input logic [7:0] exp);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b1, 8'h30, 1'b0);
    chk(name, tx_data, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    chk("reset_outputs", {tx_data, wr_reg, wr_reg_addr, wr_reg_changed, busy}, 32'h0);
    reset = 1'b0;
    ntog = 0; glitch = 0;
    prev_chg = wr_reg_changed;
    prev_wr  = {wr_reg_addr, wr_reg};
  endtask

  task automatic wait_idle(input string name, input int limit);
    for (int i = 0; i < limit && busy !== 1'b0; i++) tick();
    chk(name, busy, 1'b0);
  endtask

  task automatic wait_toggle(input string name, input int limit);
    int n0;
    n0 = ntog;
    for (int i = 0; i < limit && ntog == n0; i++) tick();
    chk(name, ntog - n0, 1);
  endtask

  initial begin
    int t0, n0, bad;
    reset = 1'b1; frame_start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    tx_req = 1'b0; status_reg = 32'h0;

    //             fs rv rd     tr st             | tx     wr      ad  ch bz
    vt[0]  = mk(1, 0, 8'h00, 0, 32'h0000_02A5, 8'h00, 12'h000, 4'h0, 0, 0);
    vt[1]  = mk(0, 1, 8'h20, 0, 32'h0000_02A5, 8'hA5, 12'h000, 4'h0, 0, 0);
    vt[2]  = mk(0, 0, 8'h00, 0, 32'h0000_0000, 8'hA5, 12'h000, 4'h0, 0, 0);
    vt[3]  = mk(0, 0, 8'h00, 1, 32'h0000_0000, 8'h02, 12'h000, 4'h0, 0, 0);
    vt[4]  = mk(0, 0, 8'h00, 1, 32'h0000_0000, 8'h00, 12'h000, 4'h0, 0, 0);
    vt[5]  = mk(0, 0, 8'h00, 1, 32'h0000_0000, 8'h00, 12'h000, 4'h0, 0, 0);
    vt[6]  = mk(0, 0, 8'h00, 1, 32'h0000_0000, 8'h00, 12'h000, 4'h0, 0, 0);
    vt[7]  = mk(1, 1, 8'h20, 0, 32'hDEAD_BEEF, 8'hEF, 12'h000, 4'h0, 0, 0);
    vt[8]  = mk(0, 0, 8'h00, 1, 32'h0000_0000, 8'hBE, 12'h000, 4'h0, 0, 0);
    vt[9]  = mk(0, 0, 8'h00, 1, 32'h0000_0000, 8'hAD, 12'h000, 4'h0, 0, 0);
    vt[10] = mk(0, 1, 8'h10, 0, 32'h0000_0000, 8'hAD, 12'h000, 4'h0, 0, 0);
    vt[11] = mk(0, 0, 8'h00, 1, 32'h0000_0000, 8'hDE, 12'h000, 4'h0, 0, 0);
    vt[12] = mk(0, 0, 8'h00, 1, 32'h0000_0000, 8'h00, 12'h000, 4'h0, 0, 0);
    vt[13] = mk(0, 0, 8'h00, 1, 32'h0000_0000, 8'h00, 12'h000, 4'h0, 0, 0);
    vt[14] = mk(0, 1, 8'h20, 0, 32'h1234_5678, 8'h00, 12'h000, 4'h0, 0, 0);
    vt[15] = mk(1, 0, 8'h00, 0, 32'h0000_0000, 8'h00, 12'h000, 4'h0, 0, 0);
    vt[16] = mk(0, 1, 8'h70, 0, 32'h0000_0000, 8'h00, 12'h000, 4'h0, 0, 0);
    vt[17] = mk(0, 1, 8'h1F, 0, 32'h0000_0000, 8'h00, 12'h000, 4'h0, 0, 0);
    vt[18] = mk(0, 1, 8'hFF, 0, 32'h0000_0000, 8'h00, 12'h000, 4'h0, 0, 0);
    vt[19] = mk(0, 1, 8'hFF, 0, 32'h0000_0000, 8'h00, 12'h000, 4'h0, 0, 0);
    vt[20] = mk(1, 1, 8'h30, 0, 32'h0000_0000, 8'h00, 12'h000, 4'h0, 0, 0);
    vt[21] = mk(1, 0, 8'h00, 0, 32'h0000_0000, 8'h00, 12'h000, 4'h0, 0, 0);
    vt[22] = mk(0, 1, 8'h10, 0, 32'h0000_0000, 8'h00, 12'h000, 4'h0, 0, 0);
    vt[23] = mk(0, 1, 8'h34, 0, 32'h0000_0000, 8'h00, 12'h000, 4'h0, 0, 0);
    vt[24] = mk(1, 0, 8'h00, 0, 32'h0000_0000, 8'h00, 12'h000, 4'h0, 0, 0);
    vt[25] = mk(0, 1, 8'hF5, 0, 32'h0000_0000, 8'h00, 12'h000, 4'h0, 0, 0);
    vt[26] = mk(1, 0, 8'h00, 0, 32'h0000_0000, 8'h00, 12'h000, 4'h0, 0, 0);
    vt[27] = mk(0, 1, 8'h12, 0, 32'h0000_0000, 8'h00, 12'h000, 4'h0, 0, 0);
    vt[28] = mk(0, 1, 8'h07, 0, 32'h0000_0000, 8'h00, 12'h000, 4'h0, 0, 0);
    vt[29] = mk(0, 1, 8'h00, 0, 32'h0000_0000, 8'h00, 12'h007, 4'h2, 1, 1);
    vt[30] = mk(0, 1, 8'hFF, 0, 32'h0000_0000, 8'h00, 12'h007, 4'h2, 1, 1);

    do_reset();

    for (int i = 0; i < 31; i++) begin
      status_reg = vt[i].st;
      drive(vt[i].fs, vt[i].rv, vt[i].rd, vt[i].tr);
      chk($sformatf("vec%0d", i), {tx_data, wr_reg, wr_reg_addr, wr_reg_changed, busy},
          {vt[i].tx, vt[i].wr, vt[i].ad, vt[i].ch, vt[i].bz});
    end
    wait_idle("vec_drain", 400);

    // single write, hold-off length
    do_reset();
    wr_frame(8'h10, 8'h34, 8'hF5);
    chk("b_first_write", {wr_reg, wr_reg_addr, wr_reg_changed, busy}, {12'h534, 4'h0, 1'b1, 1'b1});
    bad = 0;
    for (int k = 1; k <= 254; k++) begin
      tick();
      if (busy !== 1'b1) bad++;
    end
    chk("b_busy_held", bad, 0);
    tick();
    tick();
    chk("b_busy_fall", busy, 1'b0);
    chk("b_single_toggle", ntog, 1);

    // back-to-back writes: second waits for the full hold-off
    wr_frame(8'h11, 8'hAA, 8'h01);
    chk("c_first", {wr_reg, wr_reg_addr}, {12'h1AA, 4'h1});
    t0 = tog_cyc;
    wr_frame(8'h10, 8'h55, 8'h02);
    chk("c_held", {wr_reg, wr_reg_addr}, {12'h1AA, 4'h1});
    wait_toggle("c_second_toggle", 400);
    chk("c_spacing", tog_cyc - t0, 256);
    chk("c_second", {wr_reg, wr_reg_addr}, {12'h255, 4'h0});
    chk("c_no_glitch", glitch, 0);
    wait_idle("c_drain", 400);

    // submit in the very cycle the pending slot drains
    wr_frame(8'h16, 8'h44, 8'h01);
    t0 = tog_cyc;
    chk("e_w1", {wr_reg, wr_reg_addr}, {12'h144, 4'h6});
    wr_frame(8'h17, 8'h55, 8'h02);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b1, 8'h18, 1'b0);
    drive(1'b0, 1'b1, 8'h66, 1'b0);
    while (cyc < t0 + 255) tick();
    drive(1'b0, 1'b1, 8'h03, 1'b0);
    chk("e_drain_cycle", tog_cyc - t0, 256);
    chk("e_w2", {wr_reg, wr_reg_addr}, {12'h255, 4'h7});
    read_flags("e_flags_busy_only", 8'h01);
    wait_toggle("e_w3_toggle", 600);
    chk("e_w3_spacing", tog_cyc - t0, 512);
    chk("e_w3", {wr_reg, wr_reg_addr}, {12'h366, 4'h8});
    wait_idle("e_drain", 400);

    // third write inside one hold-off is dropped and flagged
    n0 = ntog;
    wr_frame(8'h13, 8'h11, 8'h00);
    wr_frame(8'h14, 8'h22, 8'h00);
    wr_frame(8'h15, 8'h33, 8'h00);
    read_flags("d_flags_ovf_busy", 8'h03);
    wait_idle("d_drain", 1000);
    chk("d_toggles", ntog - n0, 2);
    chk("d_last_write", {wr_reg, wr_reg_addr}, {12'h022, 4'h4});
    read_flags("d_flags_clear", 8'h00);
    chk("d_no_glitch", glitch, 0);

    // reset in the middle of a hold-off
    wr_frame(8'h19, 8'h77, 8'h00);
    chk("f_busy_before", busy, 1'b1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("f_reset_mid_hold", {busy, wr_reg_changed, wr_reg, wr_reg_addr, tx_data}, 32'h0);
    reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
